// File: rtl/uart_tx_frame.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional
// even parity bit, one stop bit. Every output comes straight from a flop.
module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              TXD,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cyc_r, cyc_s;
    logic [BW-1:0]     bit_r, bit_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic              par_r, par_s;
    logic              txd_r, txd_s;
    logic              ready_r, ready_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [DATA_W-1:0] shift_nx_s;
    logic              cyc_last_s;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            cyc_r   <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
            txd_r   <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cyc_r   <= cyc_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            txd_r   <= txd_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; TXD is computed one cycle ahead so it only moves on bit boundaries.
    always_comb begin
        state_s    = state_r;
        cyc_s      = cyc_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        par_s      = par_r;
        txd_s      = txd_r;
        ready_s    = ready_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        shift_nx_s = shift_r >> 1'b1;
        cyc_last_s = (cyc_r == CYC_LAST);

        case (state_r)
            ST_IDLE: begin
                if (ready_r && TX_VALID) begin
                    state_s = ST_START;
                    shift_s = TX_DATA;
                    par_s   = even_parity(TX_DATA);
                    cyc_s   = '0;
                    bit_s   = '0;
                    txd_s   = 1'b0;
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cyc_last_s) begin
                    cyc_s   = '0;
                    state_s = ST_DATA;
                    txd_s   = shift_r[0];
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            ST_DATA: begin
                if (cyc_last_s) begin
                    cyc_s   = '0;
                    shift_s = shift_nx_s;
                    if (bit_r == BIT_LAST) begin
                        bit_s = '0;
                        if (PARITY_EN != 0) begin
                            state_s = ST_PARITY;
                            txd_s   = par_r;
                        end else begin
                            state_s = ST_STOP;
                            txd_s   = 1'b1;
                        end
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                        txd_s = shift_nx_s[0];
                    end
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            ST_PARITY: begin
                if (cyc_last_s) begin
                    cyc_s   = '0;
                    state_s = ST_STOP;
                    txd_s   = 1'b1;
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            ST_STOP: begin
                if (cyc_last_s) begin
                    cyc_s   = '0;
                    state_s = ST_IDLE;
                    txd_s   = 1'b1;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cyc_s   = '0;
                bit_s   = '0;
                txd_s   = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign TXD      = txd_r;
    assign TX_READY = ready_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (4 clk/bit, 4 clk/bit with parity,
// 1 clk/bit) share stimulus and are checked against a frame-offset model.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] txd_w, ready_w, busy_w, done_w;

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .CLK(CLK), .RST(RST), .TX_DATA(tx_data), .TX_VALID(tx_valid),
        .TX_READY(ready_w[0]), .TXD(txd_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]));
    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .CLK(CLK), .RST(RST), .TX_DATA(tx_data), .TX_VALID(tx_valid),
        .TX_READY(ready_w[1]), .TXD(txd_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]));
    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .CLK(CLK), .RST(RST), .TX_DATA(tx_data), .TX_VALID(tx_valid),
        .TX_READY(ready_w[2]), .TXD(txd_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]));

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // frame without parity, bit i = i-th bit on the line
        logic       par;
        int         done0;
        int         done1;
        int         done2;
    } vec_t;

    vec_t vecs[7];
    int   cpb_a[3] = '{4, 4, 1};
    int   pen_a[3] = '{0, 1, 0};

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_busy[3];
    bit         m_done[3];
    int         m_off[3];
    logic [7:0] m_data[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Line level for bit position idx of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int pen, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return d[idx-1];
        else if (idx == 9 && pen != 0) return ^d;
        else return 1'b1;
    endfunction

    // One clock: advance the model on the edge, compare every instance at the negedge.
    task automatic tick();
        logic       rst_in, v_in, exp_txd;
        logic [7:0] d_in;
        @(posedge CLK);
        rst_in = RST;
        v_in   = tx_valid;
        d_in   = tx_data;
        for (int i = 0; i < 3; i++) begin
            if (!rst_in) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_off[i]  = 0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_off[i]++;
                    if (m_off[i] == (10 + pen_a[i]) * cpb_a[i]) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else if (v_in) begin
                    m_busy[i] = 1'b1;
                    m_off[i]  = 0;
                    m_data[i] = d_in;
                end
            end
        end
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            exp_txd = m_busy[i] ? frame_bit(m_data[i], pen_a[i], m_off[i] / cpb_a[i]) : 1'b1;
            chk($sformatf("model_out[%0d]", i),
                32'({txd_w[i], ready_w[i], busy_w[i], done_w[i]}),
                32'({exp_txd, !m_busy[i], m_busy[i], m_done[i]}));
        end
    endtask

    // Send one word to all instances and check line shape and completion timing.
    task automatic send_and_check(input vec_t v, input bit poke);
        logic [9:0] s0, s2;
        logic       p1, rdy0;
        int         d0, d1, d2;
        s0 = '0; s2 = '0; p1 = 1'b0; rdy0 = 1'b0;
        d0 = -1; d1 = -1; d2 = -1;
        tx_data  = v.data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k % 4 == 2 && k / 4 < 10) s0[k/4] = txd_w[0];
            if (k < 10) s2[k] = txd_w[2];
            if (k == 38) p1 = txd_w[1];
            if (done_w[0] && d0 < 0) begin d0 = k; rdy0 = ready_w[0]; end
            if (done_w[1] && d1 < 0) d1 = k;
            if (done_w[2] && d2 < 0) d2 = k;
            if (poke && k == 5) begin tx_data = 8'h7E; tx_valid = 1'b1; end
            if (poke && k == 6) tx_valid = 1'b0;
            tick();
        end
        chk($sformatf("line_c4_%h", v.data), 32'(s0), 32'(v.line));
        chk($sformatf("line_c1_%h", v.data), 32'(s2), 32'(v.line));
        chk($sformatf("parity_%h", v.data), 32'(p1), 32'(v.par));
        chk($sformatf("done_c4_%h", v.data), d0, v.done0);
        chk($sformatf("done_par_%h", v.data), d1, v.done1);
        chk($sformatf("done_c1_%h", v.data), d2, v.done2);
        chk($sformatf("ready_at_done_%h", v.data), 32'(rdy0), 32'd1);
    endtask

    initial begin
        logic [9:0] s0;
        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0, 40, 44, 10};
        vecs[1] = '{8'h07, 10'b1000001110, 1'b1, 40, 44, 10};
        vecs[2] = '{8'h00, 10'b1000000000, 1'b0, 40, 44, 10};
        vecs[3] = '{8'hC3, 10'b1110000110, 1'b0, 40, 44, 10};
        vecs[4] = '{8'hFF, 10'b1111111110, 1'b0, 40, 44, 10};
        vecs[5] = '{8'h3C, 10'b1001111000, 1'b0, 40, 44, 10};
        vecs[6] = '{8'h81, 10'b1100000010, 1'b0, 40, 44, 10};

        RST = 1'b0; tx_valid = 1'b1; tx_data = 8'h55;
        tick();
        tick();
        chk("reset_state", 32'({txd_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
        tx_valid = 1'b0;
        RST = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) send_and_check(vecs[i], 1'b0);

        // Hold stability: data change and a valid pulse mid-frame are ignored.
        send_and_check(vecs[6], 1'b1);

        // Back-to-back with valid held high: 0x00 then 0xFF.
        tx_data = 8'h00; tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        s0 = '0;
        for (int k = 0; k < 100; k++) begin
            if (k == 39) chk("b2b_stop", 32'({txd_w[0], busy_w[0]}), 32'(2'b11));
            if (k == 40) chk("b2b_idle", 32'({txd_w[0], ready_w[0], busy_w[0]}), 32'(3'b110));
            if (k == 41) begin
                chk("b2b_start41", 32'({txd_w[0], ready_w[0], busy_w[0]}), 32'(3'b001));
                tx_valid = 1'b0;
            end
            if (k >= 41 && (k - 41) % 4 == 2 && (k - 41) / 4 < 10) s0[(k-41)/4] = txd_w[0];
            tick();
        end
        chk("b2b_second_line", 32'(s0), 32'(10'b1111111110));

        // Reset during data bit 3 of 0x5A, then a clean 0x3C frame.
        tx_data = 8'h5A; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 17; k++) tick();
        RST = 1'b0;
        tick();
        chk("reset_mid", 32'({txd_w[0], busy_w[0], ready_w[0], done_w[0]}), 32'(4'b1010));
        RST = 1'b1;
        tick();
        send_and_check(vecs[5], 1'b0);

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            tx_data  = 8'($urandom);
            tx_valid = ($urandom_range(0, 3) != 0);
            RST      = ($urandom_range(0, 299) != 0);
            tick();
        end
        RST = 1'b1; tx_valid = 1'b0;
        for (int n = 0; n < 50; n++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line.
- Frame format: start bit, DATA_W data bits LSB first, optional even parity bit, one stop bit.
- Sits at the transmit end of the serial link. It drives the line that a matching frame receiver in the same design samples.

Parameters:
- DATA_W, 8, data bits per frame (legal 1..16).
- CLKS_PER_BIT, 4, CLK cycles each bit is held on TXD (legal >=1).
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-low.
- TX_DATA  input  DATA_W  word to transmit; sampled only on the accept edge.
- TX_VALID  input  1  word on TX_DATA is offered.
- TX_READY  output  1  transmitter can accept a word.
- TXD  output  1  serial line; idle high.
- BUSY  output  1  frame in progress.
- DONE  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rising CLK edge with RST=0):
  - TXD=1, TX_READY=1, BUSY=0, DONE=0, state=IDLE, bit and cycle counters cleared.
  - TX_VALID is ignored while RST=0.
  - Reset aborts any frame immediately; there is no partial stop bit.
- All outputs are registered.
- Frame length N = 1 + DATA_W + PARITY_EN + 1 bits. Frame duration is N*CLKS_PER_BIT cycles.
- Accept: a rising edge where RST=1, TX_READY=1 and TX_VALID=1.
  - At that edge: TX_DATA is latched into the shift register and parity (XOR of the data bits) is latched.
  - Same edge: state goes to START, TXD<=0, TX_READY<=0, BUSY<=1.
  - TX_DATA changes after the accept edge have no effect on the frame.
- State machine and transitions:
  - IDLE: TXD=1, TX_READY=1, BUSY=0.
  - START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TXD = shift register bit 0, held CLKS_PER_BIT cycles, then shift right. After DATA_W bits, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: TXD = latched parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Counters:
  - Cycle counter runs 0..CLKS_PER_BIT-1 and wraps on each bit boundary; width is clog2(CLKS_PER_BIT), minimum 1.
  - Bit counter runs 0..DATA_W-1.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Completion: at edge e0 + N*CLKS_PER_BIT (e0 = accept edge):
  - state<=IDLE, TXD stays 1, TX_READY<=1, BUSY<=0, DONE<=1.
  - DONE clears at the next edge.
- Back-to-back: with TX_VALID held high, the next accept is at e0 + N*CLKS_PER_BIT + 1.
  - Minimum frame period is N*CLKS_PER_BIT + 1 cycles, with exactly one idle-high cycle between frames.
- TX_VALID is ignored whenever TX_READY=0; there is no queuing. The offering side holds TX_VALID until accepted.
- TXD never glitches: it changes only on bit boundaries or on reset.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0; send 0xA5.
  - TXD, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - DONE=1 exactly 40 cycles after the accept edge; TX_READY=1 in the same cycle.
- PARITY_EN=1; send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop bit 1; DONE at 44 cycles.
- Send 0x00 -> parity bit 0.
- Back-to-back with TX_VALID held high, sending 0x00 then 0xFF:
  - Second start bit begins exactly 41 cycles after the first accept edge.
  - TXD=1 for exactly one cycle between the two frames.
- Reset mid-frame: RST=0 during data bit 3 of 0x5A.
  - Next edge: TXD=1, BUSY=0, TX_READY=1, DONE=0.
  - After RST=1, a new frame 0x3C transmits cleanly with correct timing.
- Hold stability: after accepting 0x81, change TX_DATA to 0x7E and pulse TX_VALID mid-frame.
  - Line still carries 0x81; no second accept occurs until TX_READY=1.
- CLKS_PER_BIT=1, DATA_W=8: send 0xC3.
  - Line sequence is 0,1,1,0,0,0,0,1,1,1 on consecutive cycles.
  - DONE at 10 cycles.
